pc_ctrl: RTL and testbench
==========================

// Module: pc_ctrl
// PURPOSE
//  Program-counter control stage, directly upstream of fetch. Holds the architectural PC
//  and drives it to fetch each cycle. Picks the next PC from: fetch's PC+2 (nextPC),
//  a branch/jump redirect, or the exception/return path.
//  Detects HALT in the fetched instruction and freezes the front end until reset.
// PARAMETERS
//  RESET_PC    16'h0000  PC value loaded on reset
//  EXC_VECTOR  16'h0002  handler entry PC (used only with PC_EXC_EN)
//  HALT_OPC    5'b00000  instr[15:11] encoding of HALT
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   synchronous reset, active-high
//  nextPC       in   16  PC+2 from fetch for the current PC
//  instr        in   16  instruction fetched at current PC
//  stall        in   1   hold PC (downstream not ready)
//  redirect     in   1   taken branch/jump this cycle
//  redirect_pc  in   16  redirect target
//  exc_req      in   1   raise exception (PC_EXC_EN only)
//  rti          in   1   return from exception (PC_EXC_EN only)
//  PC           out  16  current PC to fetch
//  fetch_valid  out  1   instr at PC is to be consumed downstream this cycle
//  halted       out  1   front end frozen on HALT
//  epc          out  16  saved return PC (PC_EXC_EN only, else 16'h0000)
// BEHAVIOUR
//  - Reset (sync, active-high, wins over all inputs). Loads:
//    PC=RESET_PC, state=RUN, epc=0, halted=0.
//    fetch_valid is combinational and equals 1 in the first cycle after reset.
//  - States: RUN, HALT. HALT->RUN only via rst; reset mid-halt restarts at RESET_PC.
//  - Update rule, one cycle latency, register loads at clk edge. In RUN, first true wins:
//    1 exc_req     : PC<=EXC_VECTOR, epc<=nextPC
//    2 rti         : PC<=epc
//    3 redirect    : PC<=redirect_pc
//    4 stall       : PC holds
//    5 instr[15:11]==HALT_OPC : PC holds, state<=HALT
//    6 otherwise   : PC<=nextPC
//  - Redirect and exc/rti override stall. A HALT seen while stalled is not acted on
//    until the stall drops. A HALT seen with a redirect is ignored (wrong path).
//  - redirect_pc[0] and epc-sourced bit0 are forced to 0. PC is always even.
//  - Wrap: nextPC=16'h0000 after 16'hFFFE is legal and is taken as-is.
//  - fetch_valid = (state==RUN) & ~stall & ~redirect & ~exc_req & ~rti
//    & ~(instr[15:11]==HALT_OPC). Purely combinational.
//  - In HALT: PC frozen at the HALT address, halted=1, fetch_valid=0.
//    All inputs except rst are ignored.
//  - exc_req and rti both high in one cycle: exc_req wins, and epc takes nextPC.
//  - A nested exc_req inside a handler overwrites epc. No stack.
// CONFIGURATION
//  PC_EXC_EN defined:
//    - exc_req/rti act as described in BEHAVIOUR; epc is a real 16-bit register.
//  PC_EXC_EN undefined:
//    - exc_req/rti are ignored (priorities 1-2 removed); epc tied to 16'h0000.
//    - No epc flops are instantiated.
// STRUCTURE
//  - Package pc_ctrl_pkg holds:
//    - state encoding: RUN=1'b0, HALT=1'b1
//    - HALT_OPC, RESET_PC, EXC_VECTOR defaults
//    - PC width constant: 16
//  - One sub-module, pc_reg: a 16-bit register with sync reset value and load enable.
//    - Instantiated for PC, and for epc under PC_EXC_EN.
//    - The state flop is also a pc_reg instance at width 1.
//  - Next-PC mux and priority logic are inline in pc_ctrl.
// TESTING
//  1 Reset, then feed nextPC=PC+2, non-halt instr, 4 cycles
//    -> PC 0000,0002,0004,0006; fetch_valid=1 each cycle.
//  2 At PC=0004 raise stall 2 cycles, then redirect=1 with redirect_pc=0x0121
//    -> PC holds 0004 twice, then 0x0120; fetch_valid=0 in all three cycles.
//  3 instr=16'h0000 at PC=0008 -> PC stays 0008 forever.
//    halted=1 from the next cycle; stall/redirect then have no effect.
//    rst -> PC=0000, halted=0.
//  4 Halt-class instr with redirect=1 and redirect_pc=0x0040 -> PC=0040, halted stays 0.
//    Same instr with stall=1 -> PC holds and no halt until the stall drops.
//  5 PC_EXC_EN: exc_req at PC=0010 (nextPC=0012) -> PC=0002, epc=0012.
//    Later rti -> PC=0012. exc_req+rti in one cycle -> PC=0002.
//    Without the macro: exc_req is ignored and epc=0.
//  6 PC=FFFE, nextPC=0000 -> PC=0000, fetch_valid=1.
//    rst asserted together with redirect -> PC=RESET_PC.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared constants and types for the program-counter control stage.
//   PC_W            width of the program counter
//   state_t         front-end state encoding (RUN / HALT)
//   DEF_RESET_PC    default PC loaded on reset
//   DEF_EXC_VECTOR  default exception handler entry
//   DEF_HALT_OPC    default instr[15:11] encoding of HALT
package pc_ctrl_pkg;

    localparam int PC_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] DEF_RESET_PC   = 16'h0000;
    localparam logic [PC_W-1:0] DEF_EXC_VECTOR = 16'h0002;
    localparam logic [4:0]      DEF_HALT_OPC   = 5'b00000;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: W-bit register with synchronous active-high reset and load enable.
//   clk  in   rising-edge clock
//   rst  in   synchronous reset, loads RST_VAL
//   en   in   load enable
//   d    in   next value
//   q    out  registered value
module pc_reg #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter control stage ahead of fetch.
// Holds the architectural PC, selects the next PC (exception, return,
// redirect, stall, halt, sequential) and freezes the front end on HALT
// until reset.
// Optional feature macro: PC_EXC_EN enables exc_req/rti handling and the
// epc register; without it those inputs are ignored and epc reads 0.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   nextPC       PC+2 from fetch for the current PC
//   instr        instruction fetched at the current PC
//   stall        hold PC
//   redirect     taken branch/jump, target in redirect_pc
//   exc_req/rti  raise exception / return from exception
//   PC           current PC driven to fetch
//   fetch_valid  instruction at PC is consumed downstream this cycle
//   halted       front end frozen on HALT
//   epc          saved return PC
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [PC_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter logic [4:0]      HALT_OPC   = DEF_HALT_OPC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] nextPC,
    input  logic [PC_W-1:0] instr,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            exc_req,
    input  logic            rti,
    output logic [PC_W-1:0] PC,
    output logic            fetch_valid,
    output logic            halted,
    output logic [PC_W-1:0] epc
);

    logic [0:0]      state_q;
    state_t          state;
    state_t          state_d;
    logic            state_en;
    logic [PC_W-1:0] pc_d;
    logic            pc_en;
    logic            is_halt;
    logic            exc_active;
    logic [10:0]     unused_instr_lo;

    assign state   = state_t'(state_q);
    assign is_halt = (instr[15:11] == HALT_OPC);
    assign unused_instr_lo = instr[10:0];

`ifdef PC_EXC_EN
    logic epc_en;

    assign exc_active = exc_req | rti;

    pc_reg #(.W(PC_W), .RST_VAL('0)) u_epc (
        .clk (clk),
        .rst (rst),
        .en  (epc_en),
        .d   (nextPC),
        .q   (epc)
    );
`else
    logic unused_exc;

    assign exc_active = 1'b0;
    assign unused_exc = exc_req ^ rti;
    assign epc        = '0;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        pc_d     = PC;
        pc_en    = 1'b0;
        state_d  = state;
        state_en = 1'b0;
`ifdef PC_EXC_EN
        epc_en   = 1'b0;
`endif
        if (state == RUN) begin
`ifdef PC_EXC_EN
            if (exc_req) begin
                // exc_req beats a simultaneous rti; epc takes the fall-through PC.
                pc_d   = EXC_VECTOR;
                pc_en  = 1'b1;
                epc_en = 1'b1;
            end else if (rti) begin
                pc_d  = epc;
                pc_en = 1'b1;
            end else
`endif
            if (redirect) begin
                // A HALT on the redirected (wrong) path is deliberately ignored.
                pc_d  = redirect_pc;
                pc_en = 1'b1;
            end else if (stall) begin
                pc_en = 1'b0;
            end else if (is_halt) begin
                state_d  = HALT;
                state_en = 1'b1;
            end else begin
                pc_d  = nextPC;
                pc_en = 1'b1;
            end
        end
    end

    // Bit 0 is cleared on every load so the PC can never become odd.
    pc_reg #(.W(PC_W), .RST_VAL(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   ({pc_d[PC_W-1:1], 1'b0}),
        .q   (PC)
    );

    pc_reg #(.W(1), .RST_VAL(1'(RUN))) u_state (
        .clk (clk),
        .rst (rst),
        .en  (state_en),
        .d   (1'(state_d)),
        .q   (state_q)
    );

    assign halted      = (state == HALT);
    assign fetch_valid = (state == RUN) & ~stall & ~redirect & ~exc_active & ~is_halt;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: scoreboard bench for pc_ctrl. The stimulus process drives one
// cycle of inputs and pushes the hand-computed expected outputs for that
// cycle; a separate monitor pops and compares on the falling edge.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] nextPC;
    logic [15:0] instr;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        exc_req;
    logic        rti;
    logic [15:0] PC;
    logic        fetch_valid;
    logic        halted;
    logic [15:0] epc;

    localparam logic [15:0] NOP  = 16'h0800;
    localparam logic [15:0] HLT  = 16'h07FF;
    localparam logic [15:0] HLT0 = 16'h0000;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        fv;
        logic        fv_chk;
        logic        h;
        logic [15:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .nextPC      (nextPC),
        .instr       (instr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc_req     (exc_req),
        .rti         (rti),
        .PC          (PC),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .epc         (epc)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        n_checks++;
        if (PC !== e.pc || halted !== e.h || epc !== e.epc ||
            (e.fv_chk && fetch_valid !== e.fv)) begin
            n_errors++;
            $display("FAIL %s: got PC=%h fv=%b halted=%b epc=%h, want PC=%h fv=%b%s halted=%b epc=%h",
                     e.name, PC, fetch_valid, halted, epc,
                     e.pc, e.fv, e.fv_chk ? "" : "(any)", e.h, e.epc);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) check(exp_q.pop_front());
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic drive(input logic r, input logic [15:0] npc, input logic [15:0] ins,
                         input logic st, input logic rd, input logic [15:0] rpc,
                         input logic ex, input logic rt);
        @(posedge clk);
        #1;
        rst = r; nextPC = npc; instr = ins; stall = st;
        redirect = rd; redirect_pc = rpc; exc_req = ex; rti = rt;
    endtask

    task automatic push(input string name, input logic [15:0] pc, input logic fv,
                        input logic fv_chk, input logic h, input logic [15:0] e_epc);
        exp_t e;
        e.name = name; e.pc = pc; e.fv = fv; e.fv_chk = fv_chk; e.h = h; e.epc = e_epc;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; nextPC = '0; instr = NOP; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; exc_req = 1'b0; rti = 1'b0;

        // Reset held over two edges.
        drive(1, 16'h0002, NOP, 0, 0, 16'h0000, 0, 0);
        push("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);

        // 1: sequential fetch.
        drive(0, 16'h0002, NOP, 0, 0, 16'h0000, 0, 0); push("seq_0000", 16'h0000, 1, 1, 0, 0);
        drive(0, 16'h0004, NOP, 0, 0, 16'h0000, 0, 0); push("seq_0002", 16'h0002, 1, 1, 0, 0);
        drive(0, 16'h0006, NOP, 0, 0, 16'h0000, 0, 0); push("seq_0004", 16'h0004, 1, 1, 0, 0);
        drive(0, 16'h0008, NOP, 0, 0, 16'h0000, 0, 0); push("seq_0006", 16'h0006, 1, 1, 0, 0);

        // 3: HALT at 0008, then stall/redirect ignored while halted.
        drive(0, 16'h000A, HLT0, 0, 0, 16'h0000, 0, 0); push("halt_seen", 16'h0008, 0, 1, 0, 0);
        drive(0, 16'h000A, NOP, 1, 1, 16'h0040, 0, 0);  push("halted_1", 16'h0008, 0, 1, 1, 0);
        drive(0, 16'h000A, NOP, 0, 1, 16'h0040, 1, 1);  push("halted_2", 16'h0008, 0, 1, 1, 0);
        drive(0, 16'h000A, NOP, 0, 0, 16'h0000, 0, 0);  push("halted_3", 16'h0008, 0, 1, 1, 0);

        // 6b: reset together with redirect restarts at RESET_PC.
        drive(1, 16'h000A, NOP, 0, 1, 16'h0040, 0, 0);  push("halted_at_rst", 16'h0008, 0, 1, 1, 0);
        drive(0, 16'h0002, NOP, 0, 0, 16'h0000, 0, 0);  push("rst_redirect", 16'h0000, 1, 1, 0, 0);

        // 2: stall twice at 0004, then redirect to odd target.
        drive(0, 16'h0004, NOP, 0, 0, 16'h0000, 0, 0);  push("s2_0002", 16'h0002, 1, 1, 0, 0);
        drive(0, 16'h0006, NOP, 1, 0, 16'h0000, 0, 0);  push("stall_1", 16'h0004, 0, 1, 0, 0);
        drive(0, 16'h0006, NOP, 1, 0, 16'h0000, 0, 0);  push("stall_2", 16'h0004, 0, 1, 0, 0);
        drive(0, 16'h0006, NOP, 0, 1, 16'h0121, 0, 0);  push("redirect", 16'h0004, 0, 1, 0, 0);

        // 4: HALT with redirect ignored; HALT under stall deferred.
        drive(0, 16'h0122, HLT, 0, 1, 16'h0041, 0, 0);  push("redir_even", 16'h0120, 0, 1, 0, 0);
        drive(0, 16'h0042, HLT, 1, 0, 16'h0000, 0, 0);  push("halt_stall1", 16'h0040, 0, 1, 0, 0);
        drive(0, 16'h0042, HLT, 1, 0, 16'h0000, 0, 0);  push("halt_stall2", 16'h0040, 0, 1, 0, 0);
        drive(0, 16'h0042, HLT, 0, 0, 16'h0000, 0, 0);  push("halt_nostall", 16'h0040, 0, 1, 0, 0);
        drive(0, 16'h0042, NOP, 0, 0, 16'h0000, 0, 0);  push("halt_late", 16'h0040, 0, 1, 1, 0);
        drive(1, 16'h0002, NOP, 0, 0, 16'h0000, 0, 0);  push("halt_at_rst2", 16'h0040, 0, 1, 1, 0);

        // 6a: wrap from FFFE to 0000.
        drive(0, 16'h0002, NOP, 0, 1, 16'hFFFF, 0, 0);  push("to_fffe", 16'h0000, 0, 1, 0, 0);
        drive(0, 16'h0000, NOP, 0, 0, 16'h0000, 0, 0);  push("at_fffe", 16'hFFFE, 1, 1, 0, 0);
        drive(0, 16'h0002, NOP, 0, 1, 16'h0010, 0, 0);  push("wrap_0000", 16'h0000, 0, 1, 0, 0);

        // 5: exception / return.
`ifdef PC_EXC_EN
        drive(0, 16'h0012, NOP, 0, 0, 16'h0000, 1, 0);  push("exc_at_0010", 16'h0010, 0, 1, 0, 16'h0000);
        drive(0, 16'h0004, NOP, 0, 0, 16'h0000, 0, 0);  push("exc_vector", 16'h0002, 1, 1, 0, 16'h0012);
        drive(0, 16'h0006, NOP, 0, 0, 16'h0000, 0, 1);  push("rti_issue", 16'h0004, 0, 1, 0, 16'h0012);
        drive(0, 16'h0014, NOP, 0, 0, 16'h0000, 1, 1);  push("rti_return", 16'h0012, 0, 1, 0, 16'h0012);
        drive(0, 16'h0004, NOP, 0, 0, 16'h0000, 0, 0);  push("exc_rti_both", 16'h0002, 1, 1, 0, 16'h0014);
`else
        drive(0, 16'h0012, NOP, 0, 0, 16'h0000, 1, 0);  push("exc_ignored", 16'h0010, 0, 0, 0, 16'h0000);
        drive(0, 16'h0014, NOP, 0, 0, 16'h0000, 0, 1);  push("exc_no_effect", 16'h0012, 0, 0, 0, 16'h0000);
        drive(0, 16'h0016, NOP, 0, 0, 16'h0000, 0, 0);  push("rti_no_effect", 16'h0014, 1, 1, 0, 16'h0000);
`endif

        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
